// File: rtl/softmax_ru_seq.sv
// softmax_ru_seq: two-pass Q8.8 softmax sequencer sharing one RU datapath.
// Optional macro SOFTMAX_RU_SEQ_PERF_EN adds the o_perf_cycles busy-cycle counter.
module softmax_ru_seq #(
  parameter int VEC_LEN = 64,
  parameter int ADDR_W  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [ADDR_W:0] i_len,
  output logic            o_busy,
  output logic            o_done,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [15:0]     i_in_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [15:0]     o_out_data,
  output logic            o_out_last,
  output logic            o_ru_valid_in,
  output logic [15:0]     o_ru_in_0,
  output logic [15:0]     o_ru_in_1,
  output logic            o_ru_sel_mult,
  output logic            o_ru_sel_mux,
  output logic            o_ru_en,
  output logic            o_ru_rst,
  input  logic [15:0]     i_ru_out_0,
  input  logic [15:0]     i_ru_out_1,
  input  logic            i_ru_valid_out
`ifdef SOFTMAX_RU_SEQ_PERF_EN
  ,
  output logic [31:0]     o_perf_cycles
`endif
);
  localparam logic [ADDR_W:0] LP_N = (ADDR_W+1)'(VEC_LEN);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_P1, S_D1, S_P2, S_D2, S_DONE} state_t;
  state_t            r_state, w_state_nx;
  logic [ADDR_W:0]   r_n, r_idx, r_rcnt, w_len;
  logic [15:0]       r_max, r_sum, r_out_data;
  logic              r_out_valid, r_out_last, r_busy, r_done;
  logic [1:0]        r_rst_q;
  logic [15:0]       r_buf [VEC_LEN];
  logic              w_start_acc, w_load_hs, w_issuing, w_issue, w_res1, w_res2;
  logic              w_stall, w_pass_start, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [15:0]       w_wdata, w_rdata;
  logic [16:0]       w_sum_add;

  assign w_len        = (i_len > LP_N) ? LP_N : i_len;
  assign w_start_acc  = (r_state == S_IDLE) && i_start;
  assign w_stall      = r_out_valid && !i_out_ready;
  assign w_load_hs    = (r_state == S_LOAD) && i_in_valid;
  assign w_issuing    = (r_state == S_P1) || (r_state == S_P2);
  assign w_issue      = w_issuing && o_ru_en;
  assign w_res1       = i_ru_valid_out && o_ru_en && ((r_state == S_P1) || (r_state == S_D1));
  assign w_res2       = i_ru_valid_out && o_ru_en && ((r_state == S_P2) || (r_state == S_D2));
  assign w_pass_start = ((r_state == S_LOAD) && (w_state_nx == S_P1)) ||
                        ((r_state == S_D1) && (w_state_nx == S_P2));
  assign w_rdata      = r_buf[r_idx[ADDR_W-1:0]];
  assign w_sum_add    = {1'b0, r_sum} + {1'b0, i_ru_out_1};
  assign w_we         = w_load_hs || w_res1;
  assign w_waddr      = w_load_hs ? r_idx[ADDR_W-1:0] : r_rcnt[ADDR_W-1:0];
  assign w_wdata      = w_load_hs ? i_in_data : i_ru_out_0;

  // RU stays disabled while its own reset is asserted so no stale strobe is counted
  assign o_ru_en       = !r_rst_q[1] && !w_stall;
  assign o_ru_rst      = r_rst_q[1];
  assign o_ru_valid_in = w_issue;
  assign o_ru_in_0     = (r_state == S_P1) ? r_max : ((r_state == S_P2) ? r_sum : '0);
  assign o_ru_in_1     = w_issuing ? w_rdata : '0;
  assign o_ru_sel_mux  = (r_state == S_P1) || (r_state == S_D1);
  assign o_ru_sel_mult = (r_state == S_P1) || (r_state == S_D1);
  assign o_in_ready    = r_state == S_LOAD;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;
  assign o_out_last    = r_out_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nx = (w_len == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (w_load_hs && (r_idx == r_n - 1'b1)) w_state_nx = S_P1;
      S_P1:    if (w_issue && (r_idx == r_n - 1'b1)) w_state_nx = S_D1;
      S_D1:    if (r_rcnt == r_n) w_state_nx = S_P2;
      S_P2:    if (w_issue && (r_idx == r_n - 1'b1)) w_state_nx = S_D2;
      S_D2:    if ((r_rcnt == r_n) && (!r_out_valid || i_out_ready)) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_rcnt      <= '0;
      r_max       <= '0;
      r_sum       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rst_q     <= 2'b11;
    end else begin
      r_state <= w_state_nx;
      r_rst_q <= {r_rst_q[0], 1'b0};
      r_done  <= r_state == S_DONE;
      r_busy  <= w_start_acc ? 1'b1 : (r_done ? 1'b0 : r_busy);
      r_idx   <= (w_state_nx != r_state) ? '0 : ((w_load_hs || w_issue) ? r_idx + 1'b1 : r_idx);
      r_rcnt  <= w_pass_start ? '0 : ((w_res1 || w_res2) ? r_rcnt + 1'b1 : r_rcnt);
      if (w_start_acc) begin
        r_n   <= w_len;
        r_sum <= '0;
      end
      if (w_load_hs)
        r_max <= ((r_idx == '0) || ($signed(i_in_data) > $signed(r_max))) ? i_in_data : r_max;
      if (w_res1)
        r_sum <= (w_sum_add[16:15] != 2'b00) ? 16'h7FFF : w_sum_add[15:0];
      if (w_res2) begin
        r_out_data <= i_ru_out_1;
        r_out_last <= r_rcnt == r_n - 1'b1;
      end
      r_out_valid <= w_res2 ? 1'b1 : (i_out_ready ? 1'b0 : r_out_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_buf[w_waddr] <= w_wdata;
  end

`ifdef SOFTMAX_RU_SEQ_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_perf <= '0;
    else        r_perf <= w_start_acc ? '0 : (r_busy ? r_perf + 32'd1 : r_perf);
  end
  assign o_perf_cycles = r_perf;
`endif
endmodule

// File: tb/tb_softmax_ru_seq.sv
// tb_softmax_ru_seq: directed vectors for softmax_ru_seq with a 3-stage behavioural RU.
module tb_softmax_ru_seq;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 1;
  logic [6:0]  len = 0;
  logic [15:0] in_data = 0;
  logic        busy, done, in_ready, out_valid, out_last, ru_valid_in;
  logic [15:0] out_data, ru_in_0, ru_in_1, ru_out_0, ru_out_1;
  logic        ru_sel_mult, ru_sel_mux, ru_en, ru_rst, ru_valid_out;
`ifdef SOFTMAX_RU_SEQ_PERF_EN
  logic [31:0] perf;
`endif
  int checks = 0, errors = 0;

  softmax_ru_seq dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_len(len), .o_busy(busy), .o_done(done),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data), .o_out_last(out_last),
    .o_ru_valid_in(ru_valid_in), .o_ru_in_0(ru_in_0), .o_ru_in_1(ru_in_1),
    .o_ru_sel_mult(ru_sel_mult), .o_ru_sel_mux(ru_sel_mux), .o_ru_en(ru_en), .o_ru_rst(ru_rst),
    .i_ru_out_0(ru_out_0), .i_ru_out_1(ru_out_1), .i_ru_valid_out(ru_valid_out)
`ifdef SOFTMAX_RU_SEQ_PERF_EN
    , .o_perf_cycles(perf)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RU: pass 1 y=(x-max)*log2e, pass 2 y=x-log2(sum); out_1 = 2^y, all Q8.8
  function automatic logic [31:0] ru_calc(input logic [15:0] a, input logic [15:0] b,
                                          input logic mux, input logic mult);
    real xa, xb, y, p;
    int q0, q1;
    xb = real'($signed(b)) / 256.0;
    xa = mux ? real'($signed(a)) / 256.0 : $ln(real'((a == 16'd0) ? 16'd1 : a) / 256.0) / $ln(2.0);
    y  = (xb - xa) * (mult ? 1.4426950408889634 : 1.0);
    q0 = $rtoi(y * 256.0 + ((y < 0.0) ? -0.5 : 0.5));
    q0 = (q0 > 32767) ? 32767 : ((q0 < -32768) ? -32768 : q0);
    p  = $pow(2.0, real'(q0) / 256.0) * 256.0;
    q1 = (p > 32767.0) ? 32767 : $rtoi(p + 0.5);
    return {q0[15:0], q1[15:0]};
  endfunction

  logic        pv [3];
  logic [31:0] pd [3];
  always @(posedge clk) begin
    if (ru_rst) begin
      for (int i = 0; i < 3; i++) pv[i] <= 1'b0;
    end else if (ru_en) begin
      pv[0] <= ru_valid_in;
      pd[0] <= ru_calc(ru_in_0, ru_in_1, ru_sel_mux, ru_sel_mult);
      for (int i = 1; i < 3; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign ru_valid_out = pv[2];
  assign ru_out_0     = pd[2][31:16];
  assign ru_out_1     = pd[2][15:0];

  task automatic chk(input string nm, input int act, input int exp, input int tol = 0);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  typedef struct {
    int          len;
    logic [15:0] d [8];
    logic [15:0] e [8];
    bit          tog;
    bit          poke;
  } vec_t;
  vec_t tbl [5];

  task automatic run_vec(input vec_t v, input string tag);
    int nexp = (v.len > 64) ? 64 : v.len;
    int li = 0, no = 0, dones = 0, busy_cyc = 0, rvi = 0, sum = 0, post = 0, cyc = 0;
    bit pstall = 0;
    logic [15:0] pdat = 0;
    logic plast = 0;
    @(negedge clk);
    len = 7'(v.len);
    start = 1;
    out_ready = 1;
    while (post < 3 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (pstall) begin
        chk({tag, "_hold_data"}, out_data, pdat);
        chk({tag, "_hold_last"}, out_last, plast);
      end
      busy_cyc += int'(busy);
      if (done) dones++;
      if (dones > 0) post++;
      out_ready = v.tog ? !out_ready : 1'b1;
      start = v.poke && no == 5;
      in_valid = li < v.len;
      in_data = v.d[(li < 8) ? li : 7];
      #1;
      chk({tag, "_ru_en"}, ru_en, !(out_valid && !out_ready));
      rvi += int'(ru_valid_in);
      if (in_valid && in_ready) li++;
      if (out_valid && out_ready) begin
        chk($sformatf("%s_out%0d", tag, no), out_data, v.e[(no < 8) ? no : 7], 3);
        chk($sformatf("%s_last%0d", tag, no), out_last, no == nexp - 1);
        sum += int'(out_data);
        no++;
      end
      pstall = out_valid && !out_ready;
      pdat = out_data;
      plast = out_last;
    end
    in_valid = 0;
    start = 0;
    out_ready = 1;
    chk({tag, "_no_timeout"}, cyc < 4000, 1);
    chk({tag, "_loads"}, li, nexp);
    chk({tag, "_outs"}, no, nexp);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_idle_after"}, busy, 0);
    if (nexp > 0) chk({tag, "_sum"}, sum, 256, 8);
    else begin
      chk({tag, "_busy_cycles"}, busy_cyc, 2);
      chk({tag, "_ru_valid_in"}, rvi, 0);
    end
`ifdef SOFTMAX_RU_SEQ_PERF_EN
    chk({tag, "_perf"}, perf, busy_cyc);
`endif
  endtask

  initial begin
    int seen;
    tbl[0] = '{2,   '{16'h0100, 16'h0100, 0, 0, 0, 0, 0, 0},
                    '{16'h0080, 16'h0080, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0};
    tbl[1] = '{4,   '{16'h0000, 16'hFF00, 16'hFE00, 16'h0200, 0, 0, 0, 0},
                    '{16'h001D, 16'h000B, 16'h0004, 16'h00D5, 0, 0, 0, 0}, 1'b0, 1'b0};
    tbl[2] = '{0,   '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0};
    tbl[3] = '{3,   '{16'h0000, 16'h0100, 16'h0200, 0, 0, 0, 0, 0},
                    '{16'h0017, 16'h003F, 16'h00AA, 0, 0, 0, 0, 0}, 1'b1, 1'b0};
    tbl[4] = '{100, '{0, 0, 0, 0, 0, 0, 0, 0},
                    '{4, 4, 4, 4, 4, 4, 4, 4}, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_outs_zero", int'(|{busy, done, in_ready, out_valid, out_data, out_last, ru_valid_in,
                                 ru_in_0, ru_in_1, ru_sel_mult, ru_sel_mux, ru_en}), 0);
    chk("rst_ru_rst", ru_rst, 1);
    rst_n = 1;
    @(negedge clk);
    chk("ru_rst_hold", ru_rst, 1);
    @(negedge clk);
    chk("ru_rst_release", ru_rst, 0);
    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("v%0d", i));
    // Abort a vector in pass 1 right after its first issue
    @(negedge clk);
    len = 2;
    start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge clk);
      in_valid = 1;
      in_data = 16'h0100;
      #1;
      seen = int'(ru_valid_in);
    end
    chk("abort_issue_seen", seen, 1);
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("abort_outs_zero", int'(|{busy, done, in_ready, out_valid, out_data, out_last, ru_valid_in,
                                   ru_in_0, ru_in_1, ru_sel_mult, ru_sel_mux, ru_en}), 0);
    chk("abort_ru_rst", ru_rst, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("abort_ru_rst_hold", ru_rst, 1);
    @(negedge clk);
    chk("abort_ru_rst_release", ru_rst, 0);
    run_vec(tbl[0], "after_abort");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
